// File: rtl/pattern_detector_pkg.sv
// Shared types and constants for the serial pattern detector.
package pattern_detector_pkg;

    typedef enum logic [1:0] {
        ST_UNCFG = 2'd0,
        ST_FILL  = 2'd1,
        ST_ARMED = 2'd2
    } state_e;

    localparam logic OVERLAP    = 1'b0;
    localparam logic NONOVERLAP = 1'b1;
    localparam int   MIN_LEN    = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector with programmable pattern/length, overlap mode
// and a saturating match counter.
//
// state    | meaning
// ST_UNCFG | no legal configuration latched; samples ignored
// ST_FILL  | configured, history holds fewer than len-1 valid bits
// ST_ARMED | configured, the next accepted sample can complete a match
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         serIn,
    input  logic                         inValid,
    input  logic                         cfgLoad,
    input  logic [MAX_LEN-1:0]           cfgPattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfgLen,
    input  logic                         cfgMode,
    input  logic                         cntClr,
    output logic                         w,
    output logic [CNT_W-1:0]             matchCount,
    output logic                         cfgErr,
    output logic                         armed
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               mode_q, mode_d;
    logic               err_q, err_d;
    logic               w_q, w_d;

    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic               cfg_legal;
    logic               accept;
    logic               fill_hit;
    logic               fill_ready;
    logic               hit;

    // Shifting by len >= MAX_LEN yields zero, so the mask covers the full width.
    assign len_mask   = ~({MAX_LEN{1'b1}} << len_q);
    assign hist_shift = {hist_q[MAX_LEN-2:0], serIn};
    assign cfg_legal  = (cfgLen >= LEN_W'(MIN_LEN)) && (cfgLen <= LEN_W'(MAX_LEN));
    assign accept     = inValid && !cfgLoad && (state_q != ST_UNCFG);
    assign fill_inc   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    assign fill_hit   = ((LEN_W+1)'(fill_q) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);
    assign fill_ready = ((LEN_W+1)'(fill_inc) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);
    assign hit        = accept && fill_hit && ((hist_shift & len_mask) == (pat_q & len_mask));

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        len_d   = len_q;
        fill_d  = fill_q;
        mode_d  = mode_q;
        err_d   = err_q;
        w_d     = 1'b0;
        if (cfgLoad) begin
            pat_d   = cfgPattern;
            len_d   = cfgLen;
            mode_d  = cfgMode;
            err_d   = !cfg_legal;
            hist_d  = '0;
            fill_d  = '0;
            state_d = cfg_legal ? ST_FILL : ST_UNCFG;
        end else if (accept) begin
            hist_d = hist_shift;
            w_d    = hit;
            if (hit && (mode_q == NONOVERLAP)) begin
                fill_d  = '0;
                state_d = ST_FILL;
            end else begin
                fill_d  = fill_inc;
                state_d = fill_ready ? ST_ARMED : ST_FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_UNCFG;
            hist_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
            w_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            w_q     <= w_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_d),
        .clr   (cntClr),
        .count (matchCount)
    );

    assign w      = w_q;
    assign cfgErr = err_q;
    assign armed  = (state_q == ST_ARMED);

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector: a default instance plus a CNT_W=2
// instance sharing the same stimulus for the saturation case.
module tb_pattern_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serIn = 1'b0;
    logic       inValid = 1'b0;
    logic       cfgLoad = 1'b0;
    logic [7:0] cfgPattern = '0;
    logic [3:0] cfgLen = '0;
    logic       cfgMode = 1'b0;
    logic       cntClr = 1'b0;

    logic       w, cfgErr, armed;
    logic [7:0] matchCount;
    logic       w2, cfgErr2, armed2;
    logic [1:0] matchCount2;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wm;
    int          gh;
    logic        ws;

    pattern_detector #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .serIn(serIn), .inValid(inValid),
        .cfgLoad(cfgLoad), .cfgPattern(cfgPattern), .cfgLen(cfgLen),
        .cfgMode(cfgMode), .cntClr(cntClr), .w(w), .matchCount(matchCount),
        .cfgErr(cfgErr), .armed(armed)
    );

    pattern_detector #(.MAX_LEN(8), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .serIn(serIn), .inValid(inValid),
        .cfgLoad(cfgLoad), .cfgPattern(cfgPattern), .cfgLen(cfgLen),
        .cfgMode(cfgMode), .cntClr(cntClr), .w(w2), .matchCount(matchCount2),
        .cfgErr(cfgErr2), .armed(armed2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // w is read 1 time unit after the sampling edge, i.e. the cycle after the sample.
    task automatic send_bit(input logic b, input logic clr, output logic w_seen);
        @(negedge clk);
        serIn   = b;
        inValid = 1'b1;
        cntClr  = clr;
        @(posedge clk);
        #1;
        w_seen  = w;
        inValid = 1'b0;
        cntClr  = 1'b0;
    endtask

    // bits[n-1] goes first; wmask[i] records w after sample i+1.
    task automatic send_stream(input logic [31:0] bits, input int n, input int gap,
                               output logic [31:0] wmask, output int gap_hits);
        logic b_w;
        wmask    = '0;
        gap_hits = 0;
        for (int i = 0; i < n; i++) begin
            send_bit(bits[n-1-i], 1'b0, b_w);
            wmask[i] = b_w;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                if (w) gap_hits++;
            end
        end
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic mode);
        @(negedge clk);
        cfgLoad    = 1'b1;
        cfgPattern = pat;
        cfgLen     = len;
        cfgMode    = mode;
        @(posedge clk);
        #1;
        cfgLoad = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        cntClr = 1'b1;
        @(posedge clk);
        #1;
        cntClr = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_w", w, 0);
        check_val("rst_count", matchCount, 0);
        check_val("rst_cfgerr", cfgErr, 0);
        check_val("rst_armed", armed, 0);
        @(negedge clk);
        rst = 1'b1;

        // Unconfigured: nothing may match
        send_stream(32'b0111110, 7, 0, wm, gh);
        check_val("uncfg_w", wm, 0);
        check_val("uncfg_count", matchCount, 0);

        // Single occurrence, overlap mode
        do_cfg(8'h3E, 4'd7, 1'b0);
        check_val("cfg_armed", armed, 0);
        check_val("cfg_err", cfgErr, 0);
        send_stream(32'b011111, 6, 0, wm, gh);
        check_val("fill_w", wm, 0);
        check_val("fill_armed", armed, 1);
        send_bit(1'b0, 1'b0, ws);
        check_val("single_w", ws, 1);
        check_val("single_count", matchCount, 1);

        // Two occurrences sharing bit 7
        pulse_clr();
        check_val("clr_count", matchCount, 0);
        do_cfg(8'h3E, 4'd7, 1'b0);
        send_stream(32'b0111110111110, 13, 0, wm, gh);
        check_val("ovl13_w", wm, 32'h1040);
        check_val("ovl13_count", matchCount, 2);

        // Non-overlapping: the shared bit 7 is consumed by the first match
        pulse_clr();
        do_cfg(8'h3E, 4'd7, 1'b1);
        send_stream(32'b0111110111110, 13, 0, wm, gh);
        check_val("nov13_w", wm, 32'h0040);
        check_val("nov13_count", matchCount, 1);
        pulse_clr();
        do_cfg(8'h3E, 4'd7, 1'b1);
        send_stream(32'b01111100111110, 14, 0, wm, gh);
        check_val("nov14_w", wm, 32'h2040);
        check_val("nov14_count", matchCount, 2);

        // Pattern 0110 on 0110110
        pulse_clr();
        do_cfg(8'h06, 4'd4, 1'b1);
        send_stream(32'b0110, 4, 0, wm, gh);
        check_val("nov4_first_w", wm, 32'h8);
        check_val("nov4_armed", armed, 0);
        send_stream(32'b110, 3, 0, wm, gh);
        check_val("nov4_tail_w", wm, 0);
        check_val("nov4_count", matchCount, 1);
        pulse_clr();
        do_cfg(8'h06, 4'd4, 1'b0);
        send_stream(32'b0110110, 7, 0, wm, gh);
        check_val("ovl4_w", wm, 32'h48);
        check_val("ovl4_count", matchCount, 2);

        // Gaps between samples
        pulse_clr();
        do_cfg(8'h3E, 4'd7, 1'b0);
        send_stream(32'b0111110111110, 13, 2, wm, gh);
        check_val("gap_w", wm, 32'h1040);
        check_val("gap_hits", gh, 0);
        check_val("gap_count", matchCount, 2);

        // cfgLoad in the same cycle as a would-be completing sample
        pulse_clr();
        do_cfg(8'h06, 4'd4, 1'b0);
        send_stream(32'b011, 3, 0, wm, gh);
        @(negedge clk);
        cfgLoad = 1'b1;
        inValid = 1'b1;
        serIn   = 1'b0;
        @(posedge clk);
        #1;
        cfgLoad = 1'b0;
        inValid = 1'b0;
        check_val("cfgcoll_w", w, 0);
        send_stream(32'b0110, 4, 0, wm, gh);
        check_val("cfgcoll_after_w", wm, 32'h8);
        check_val("cfgcoll_count", matchCount, 1);

        // Illegal lengths
        do_cfg(8'h3E, 4'd0, 1'b0);
        check_val("len0_err", cfgErr, 1);
        check_val("len0_armed", armed, 0);
        send_stream(32'b0111110, 7, 0, wm, gh);
        check_val("len0_w", wm, 0);
        do_cfg(8'h3E, 4'd9, 1'b0);
        check_val("len9_err", cfgErr, 1);
        send_stream(32'b00111110, 8, 0, wm, gh);
        check_val("len9_w", wm, 0);
        do_cfg(8'h01, 4'd1, 1'b0);
        check_val("len1_err", cfgErr, 1);
        send_stream(32'b11, 2, 0, wm, gh);
        check_val("len1_w", wm, 0);
        do_cfg(8'h3E, 4'd7, 1'b0);
        check_val("relegal_err", cfgErr, 0);

        // Reset after 5 of 7 bits
        pulse_clr();
        send_stream(32'b01111, 5, 0, wm, gh);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst_w", w, 0);
        check_val("midrst_armed", armed, 0);
        @(negedge clk);
        rst = 1'b1;
        send_stream(32'b10, 2, 0, wm, gh);
        check_val("postrst_w", wm, 0);
        do_cfg(8'h3E, 4'd7, 1'b0);
        send_stream(32'b0111110, 7, 0, wm, gh);
        check_val("replay_w", wm, 32'h40);
        check_val("replay_count", matchCount, 1);

        // Saturation on the 2-bit counter, then clear during a match
        pulse_clr();
        do_cfg(8'h06, 4'd4, 1'b0);
        send_stream(32'b0110110110110110, 16, 0, wm, gh);
        check_val("sat_w", wm, 32'h9248);
        check_val("sat_count8", matchCount, 5);
        check_val("sat_count2", matchCount2, 3);
        check_val("sat_armed2", armed2, 1);
        send_bit(1'b1, 1'b0, ws);
        send_bit(1'b1, 1'b0, ws);
        send_bit(1'b0, 1'b1, ws);
        check_val("clrhit_w", ws, 1);
        check_val("clrhit_w2", w2, 1);
        check_val("clrhit_count8", matchCount, 0);
        check_val("clrhit_count2", matchCount2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
